alu_cmd_sequencer: RTL

Initiator side of the alu datapath. It accepts packed commands over a valid/ready handshake and reads two operands from a 4-entry register file. It drives alu a/b/s, waits the alu's registered latency, then writes the result back and returns a one-cycle response. It sits between the command source (testbench or future control FSM) and the alu.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_cmd_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, sequencer states and bus payload types for the alu command path.
package alu_pkg;

   localparam int unsigned DEF_WIDTH = 40;
   localparam int unsigned OP_W      = 5;
   localparam int unsigned REG_AW    = 2;
   localparam int unsigned REG_N     = 4;

   localparam logic [OP_W-1:0] OP_NOP  = 5'b00000;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00101;
   localparam logic [OP_W-1:0] OP_ADDM = 5'b00111;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00110;
   localparam logic [OP_W-1:0] OP_SUBM = 5'b01000;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b01011;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b01100;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b10100;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b10101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_CAPTURE,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } cmd_t;

   function automatic logic is_supported(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_ADDM, OP_SUB, OP_SUBM,
         OP_MUL, OP_DIV, OP_SHL, OP_SHR: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4-entry operand register file: writeback beats an external load to the same entry,
// different entries are written together; three combinational read ports.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [WIDTH-1:0]  wb_data,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   input  logic [REG_AW-1:0] rd_addr,
   output logic [WIDTH-1:0]  rs1_data,
   output logic [WIDTH-1:0]  rs2_data,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] regs [REG_N];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < REG_N; i++) begin
            if (wb_en && wb_addr == REG_AW'(i))      regs[i] <= wb_data;
            else if (wr_en && wr_addr == REG_AW'(i)) regs[i] <= wr_data;
         end
      end
   end

   assign rs1_data = regs[rs1_addr];
   assign rs2_data = regs[rs2_addr];
   assign rd_data  = regs[rd_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts register-addressed alu commands, holds alu inputs for ALU_LAT cycles,
// writes the result back and returns a one-cycle response.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [REG_AW-1:0] cmd_rd,
   input  logic [REG_AW-1:0] cmd_rs1,
   input  logic [REG_AW-1:0] cmd_rs2,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [REG_AW-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [OP_W-1:0]   alu_s,
   input  logic [WIDTH-1:0]  alu_out,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [WIDTH-1:0]  rsp_data
);

   localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_t            state;
   state_t            state_next;
   cmd_t              cmd;
   logic [CNT_W-1:0]  lat_cnt;
   logic [REG_AW-1:0] rd_q;
   logic [WIDTH-1:0]  rs1_val;
   logic [WIDTH-1:0]  rs2_val;
   logic              cmd_ok;
   logic              wb_en;

   assign cmd    = '{op: cmd_op, rd: cmd_rd, rs1: cmd_rs1, rs2: cmd_rs2};
   assign cmd_ok = is_supported(cmd.op) && !(cmd.op == OP_DIV && rs2_val == '0);
   assign wb_en  = (state == ST_CAPTURE);

   alu_regfile #(.WIDTH(WIDTH)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .wb_en    (wb_en),
      .wb_addr  (rd_q),
      .wb_data  (alu_out),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rs1_addr (cmd.rs1),
      .rs2_addr (cmd.rs2),
      .rd_addr  (rd_addr),
      .rs1_data (rs1_val),
      .rs2_data (rs2_val),
      .rd_data  (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (cmd_valid) state_next = cmd_ok ? ST_EXEC : ST_RESP;
         ST_EXEC:    if (lat_cnt == CNT_W'(ALU_LAT - 1)) state_next = ST_CAPTURE;
         ST_CAPTURE: state_next = ST_RESP;
         ST_RESP:    state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Operands are latched at acceptance so the alu inputs stay stable through EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_ready <= 1'b1;
         lat_cnt   <= '0;
         rd_q      <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_s     <= OP_NOP;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
      end else begin
         cmd_ready <= (state_next == ST_IDLE);
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  rd_q <= cmd.rd;
                  if (cmd_ok) begin
                     alu_a   <= rs1_val;
                     alu_b   <= rs2_val;
                     alu_s   <= cmd.op;
                     lat_cnt <= '0;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                  end
               end
            end
            ST_EXEC: lat_cnt <= lat_cnt + CNT_W'(1);
            ST_CAPTURE: begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_data  <= alu_out;
               alu_s     <= OP_NOP;
            end
            default: ;
         endcase
      end
   end

endmodule
